// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: program counter, word-addressed instruction memory,
// and the IDLE/RUN/HALT sequencer that feeds Instruction_Code to the control unit.
module instruction_fetch_unit #(
  parameter int unsigned MEM_DEPTH = 64,
  parameter int unsigned ADDR_W    = 6,
  parameter logic [31:0] HALT_CODE = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic              Stall,
  input  logic              Prog_We,
  input  logic [ADDR_W-1:0] Prog_Addr,
  input  logic [31:0]       Prog_Data,
  output logic [31:0]       PC,
  output logic [31:0]       Instruction_Code,
  output logic              Instr_Valid,
  output logic              Halted,
  output logic              Fault,
  output logic [31:0]       Retired_Count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [31:0] LAST_PC = 32'(4 * (MEM_DEPTH - 1));

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        fault;
  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] word;
  logic        in_run;
  logic        is_halt_word;

  assign word         = mem[pc[ADDR_W+1:2]];
  assign in_run       = (state == S_RUN);
  assign is_halt_word = (word == HALT_CODE);

  // Memory is never cleared; writes only outside RUN and never alongside reset.
  always_ff @(posedge clk) begin
    if (!reset && !in_run && Prog_We)
      mem[Prog_Addr] <= Prog_Data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= '0;
      retired <= '0;
      fault   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (Start) begin
            state   <= S_RUN;
            pc      <= '0;
            retired <= '0;
            fault   <= 1'b0;
          end
        end
        S_RUN: begin
          if (!Stall) begin
            if (is_halt_word) begin
              state <= S_HALT;
            end else begin
              retired <= retired + 32'd1;
              // Last word retires but PC stays put so it never leaves the memory range.
              if (pc >= LAST_PC) begin
                state <= S_HALT;
                fault <= 1'b1;
              end else begin
                pc <= pc + 32'd4;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    PC               = pc;
    Retired_Count    = retired;
    Fault            = fault;
    Halted           = (state == S_HALT);
    Instruction_Code = in_run ? word : '0;
    Instr_Valid      = in_run && !is_halt_word;
  end

endmodule
